// File: rtl/mat3_mac_engine.sv
// mat3_mac_engine: 3x3 unsigned matrix multiply, C = A x B.
// One multiply-accumulate datapath is time-shared across all 27 products.
// Each product is registered first. On the next edge it is accumulated.
// A start is accepted in IDLE or DONE. It latches both operand matrices.
// Run length: 27 issue edges, 1 drain edge, then a one-cycle done pulse.
module mat3_mac_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9*DATA_W-1:0]  a_in,
    input  logic [9*DATA_W-1:0]  b_in,
    output logic [9*ACC_W-1:0]   c_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int P_W = 2 * DATA_W;

    logic [1:0]        state;
    logic [DATA_W-1:0] a_q [9];
    logic [DATA_W-1:0] b_q [9];

    // Issue counters. row and col select the element of C, and k walks the dot product.
    logic [1:0]        row;
    logic [1:0]        col;
    logic [1:0]        k;

    // Product pipeline register and its tags.
    logic [P_W-1:0]    p_q;
    logic              p_valid;
    logic              p_first;
    logic              p_last;
    logic [3:0]        p_elem;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  c_q [9];

    logic              accept;
    logic              issue_last;

    // Row-major flat index of a 3x3 element.
    function automatic logic [3:0] idx3(input logic [1:0] r, input logic [1:0] c);
        return 4'(r) * 4'd3 + 4'(c);
    endfunction

    assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign issue_last = (row == 2'd2) && (col == 2'd2) && (k == 2'd2);
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);

    // Control FSM and issue counters.
    // Ordering: k is innermost, then col, then row. This produces c11..c33 in order.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        // That way every flop samples values from before the edge.
        if (rst) begin
            state <= ST_IDLE;
            row   <= '0;
            col   <= '0;
            k     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        row   <= '0;
                        col   <= '0;
                        k     <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (k == 2'd2) begin
                        k <= '0;
                        if (col == 2'd2) begin
                            col <= '0;
                            row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end else begin
                        k <= k + 2'd1;
                    end
                    if (issue_last) state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture on accepted start.
    // Input changes after acceptance do not affect the run in progress.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the operand and result arrays are small register files, not RAM.
        // They get a real reset, because zero contents after reset are part of the contract.
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 9; i++) begin
                a_q[i] <= a_in[DATA_W*i +: DATA_W];
                b_q[i] <= b_in[DATA_W*i +: DATA_W];
            end
        end
    end

    // Issue stage: register one product A[row][k] * B[k][col] per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_elem  <= '0;
        end else begin
            p_valid <= (state == ST_RUN);
            if (state == ST_RUN) begin
                p_q     <= P_W'(a_q[idx3(row, k)]) * P_W'(b_q[idx3(k, col)]);
                p_first <= (k == 2'd0);
                p_last  <= (k == 2'd2);
                p_elem  <= idx3(row, col);
            end
        end
    end

    // Accumulator next value. It restarts from zero on the first product of each element.
    always_comb begin
        // NOTE: sum is given a value on every path, so no latch is inferred.
        sum = (p_first ? '0 : acc_q) + ACC_W'(p_q);
    end

    // Accumulate stage. The final sum of each dot product is written into its C element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            for (int i = 0; i < 9; i++) c_q[i] <= '0;
        end else if (p_valid) begin
            acc_q <= sum;
            if (p_last) c_q[p_elem] <= sum;
        end
    end

    // Flatten the result array onto the row-major output bus.
    for (genvar g = 0; g < 9; g++) begin : g_pack
        assign c_out[ACC_W*g +: ACC_W] = c_q[g];
    end

endmodule

// File: doc/mat3_mac_engine.md
Name: mat3_mac_engine

Overview:
- Pipelined 3x3 matrix-multiply compute core, C = A x B, using a single multiply-accumulate datapath time-shared over 27 products.
- Sits directly downstream of the switch/LED input controller, which loads A and B, pulses start, waits for done, then captures C for LED display.
- Operands are captured on start, so the controller may change its registers while the engine runs.

Parameters:
- DATA_W, 8: operand element width, unsigned.
- ACC_W, 16: accumulator and result element width, unsigned; results wrap modulo 2^ACC_W.

Ports:
- clk    in   1          system clock, rising edge
- rst    in   1          asynchronous, active-high reset
- start  in   1          request computation; sampled only when idle
- a_in   in   9*DATA_W   matrix A, row-major; element k (a11=k0 .. a33=k8) at [DATA_W*k +: DATA_W]
- b_in   in   9*DATA_W   matrix B, same packing
- c_out  out  9*ACC_W    matrix C, row-major; element k at [ACC_W*k +: ACC_W]
- busy   out  1          high from start acceptance until the done cycle (exclusive)
- done   out  1          single-cycle pulse: c_out holds the new complete result

Behaviour:
- Reset (asynchronous, any state): state=IDLE, c_out=0, done=0, busy=0, counters/pipeline valid flags=0, operand registers=0. Partial results are discarded. No done follows an aborted run.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 at edge E0: latch a_in/b_in, clear element index e (0..8) and k (0..2), go RUN, busy=1.
  - start=0: hold.
- RUN (issue stage):
  - Each edge, the product register p <= A[e/3][k] * B[k][e%3] (2*DATA_W bits), together with flags first=(k==0), last=(k==2), elem=e, and valid=1.
  - k increments and wraps to 0, then e increments.
  - After issuing e=8,k=2 (edge E27), go DRAIN.
  - Issue edges are E1..E27, one product per cycle with no bubbles.
- Accumulate stage, on each edge with valid=1:
  - sum = (first ? 0 : acc) + zero-extended p, truncated to ACC_W; acc <= sum.
  - If last, write c_out[elem] <= sum; c_out elements update one at a time, in order c11..c33.
- DRAIN: the final accumulate occurs at E28 (writes c33); go DONE.
- DONE: done=1, busy=0 for exactly one cycle (the cycle after E28); c_out complete. Then next edge -> IDLE.
- start in DONE cycle: accepted as if in IDLE (latch operands, go RUN), giving back-to-back runs with no idle gap.
- Latency: done is high during the 29th cycle after the start-sampling edge E0, i.e. it is registered at E28.
- start while busy (RUN/DRAIN): ignored; no restart or re-latch of operands.
- c_out holds its value after done until the next run overwrites elements; it is not cleared on start.
- Overflow: the 8x8 product is at most 65025 and fits; accumulation of 3 products wraps mod 2^ACC_W with no saturation or flag.
- a_in/b_in changes after E0 have no effect on the current run.

Test Plan:
- A=[1,2,3;4,5,6;7,8,9], B=[9,8,7;6,5,4;3,2,1], start pulse -> done exactly 29 cycles after start edge; c_out = [30,24,18;84,69,54;138,114,90]; busy high between.
- A=identity, B=[10..90 step 10] -> c_out equals B; single done pulse; later start=0 cycles give no further done.
- All A,B elements=255 -> every c element = 195075 mod 65536 = 64003 (ACC_W=16); rerun with ACC_W=18 -> 195075.
- Start accepted, then a_in zeroed next cycle, plus an extra start pulse at cycle 10 -> result still from original operands; exactly one done at cycle 29.
- rst asserted at cycle 15 of a run -> c_out=0, busy=0, done=0 immediately (asynchronous); no done until a new start; a fresh run then completes correctly.
- start held high continuously across DONE -> second run begins in the done cycle; second done 29 cycles after first; results of differing second operands are correct.
